// File: rtl/mem_port_arbiter.sv
// Purpose: shares one memory port between fetch (IF) and load/store (DM), one transaction at a time, round-robin on ties.
// Latency: grant to rvalid is 2 + MEM_LATENCY cycles for reads; writes occupy the port for 2 cycles.
// Backpressure: gnt is only given in IDLE; requesters hold req/addr/we/wdata until granted.
module mem_port_arbiter #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int MEM_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [AWIDTH-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DWIDTH-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [AWIDTH-1:0] dm_addr_i,
    input  logic [DWIDTH-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_rvalid_o,
    output logic [DWIDTH-1:0] dm_rdata_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [2:0] LAT    = 3'(MEM_LATENCY);
    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_DM = 1'b1;

    state_t            state;
    state_t            state_nxt;
    logic              last_gnt;
    logic              owner;
    logic              we_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [2:0]        cnt;
    logic              grant_if;
    logic              grant_dm;
    logic              any_gnt;
    logic              sample;

    // Arbitration: only in IDLE and never under reset; ties go to the side opposite last_gnt.
    always_comb begin
        grant_if = 1'b0;
        grant_dm = 1'b0;
        if (state == IDLE && !rst) begin
            if (if_req_i && dm_req_i) begin
                grant_if = (last_gnt == OWN_DM);
                grant_dm = (last_gnt == OWN_IF);
            end else begin
                grant_if = if_req_i;
                grant_dm = dm_req_i;
            end
        end
    end

    assign if_gnt_o = grant_if;
    assign dm_gnt_o = grant_dm;
    assign any_gnt  = grant_if | grant_dm;

    // Read data is captured at the end of ISSUE (zero latency) or at the last WAIT cycle.
    assign sample = ((state == ISSUE) && !we_q && (LAT == 3'd0)) ||
                    ((state == WAIT) && (cnt == 3'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a grant starts ISSUE, reads with latency detour through WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_gnt) state_nxt = ISSUE;
            ISSUE:   state_nxt = (we_q || (LAT == 3'd0)) ? IDLE : WAIT;
            WAIT:    if (cnt == 3'd1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory-side outputs: enables and write data are only live during ISSUE.
    always_comb begin
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        mem_data_o     = '0;
        if (state == ISSUE) begin
            mem_read_en_o  = ~we_q;
            mem_write_en_o = we_q;
            mem_data_o     = we_q ? wdata_q : '0;
        end
    end

    // Transaction capture, latency counter and registered read response.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt    <= OWN_DM;
            owner       <= OWN_IF;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            mem_addr_o  <= '0;
            cnt         <= '0;
            if_rvalid_o <= 1'b0;
            dm_rvalid_o <= 1'b0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
        end else begin
            if_rvalid_o <= 1'b0;
            dm_rvalid_o <= 1'b0;

            if (any_gnt) begin
                mem_addr_o <= grant_if ? if_addr_i : dm_addr_i;
                we_q       <= grant_dm & dm_we_i;
                wdata_q    <= (grant_dm && dm_we_i) ? dm_wdata_i : '0;
                owner      <= grant_dm ? OWN_DM : OWN_IF;
                last_gnt   <= grant_dm ? OWN_DM : OWN_IF;
            end

            if (state == ISSUE && !we_q && LAT != 3'd0) begin
                cnt <= LAT;
            end else if (state == WAIT) begin
                cnt <= cnt - 3'd1;
            end

            if (sample) begin
                if (owner == OWN_IF) begin
                    if_rvalid_o <= 1'b1;
                    if_rdata_o  <= mem_data_i;
                end else begin
                    dm_rvalid_o <= 1'b1;
                    dm_rdata_o  <= mem_data_i;
                end
            end
        end
    end

endmodule
